// File: rtl/img_loader.sv
// Raster-to-column-major pixel loader feeding the median-filter image memory.
// Optional frame checksum output enabled by defining IMG_LOADER_CHECKSUM_EN.
module img_loader #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_sof,
    output logic [13:0] img_addr,
    output logic [7:0]  img_data,
    output logic        img_wen,
    output logic        ready,
    input  logic        busy,
    output logic        sof_err
`ifdef IMG_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    // state  | meaning
    // S_IDLE | discard beats until an SOF beat arrives
    // S_LOAD | write one pixel per accepted beat
    // S_HAND | frame complete, ready offered to the filter engine
    // S_WAIT | engine owns the image memory, wait for busy to clear
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HAND = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    localparam logic [6:0] X_MAX = 7'(IMG_W - 1);
    localparam logic [6:0] Y_MAX = 7'(IMG_H - 1);

    logic [1:0]  r_state;
    logic [6:0]  r_x;
    logic [6:0]  r_y;
    logic        r_s_ready;
    logic [13:0] r_addr;
    logic [7:0]  r_data;
    logic        r_wen;
    logic        r_ready;
    logic        r_sof_err;

    logic [1:0]  w_next;
    logic        w_accept;
    logic        w_write;
    logic        w_sof_err;
    logic [6:0]  w_x_next;
    logic [6:0]  w_y_next;
    logic [13:0] w_waddr;

    assign w_accept = s_valid & r_s_ready;

    always_comb begin
        w_next    = r_state;
        w_write   = 1'b0;
        w_sof_err = 1'b0;
        w_x_next  = r_x;
        w_y_next  = r_y;
        w_waddr   = {r_x, r_y};
        case (r_state)
            S_IDLE: begin
                if (w_accept && s_sof) begin
                    w_write  = 1'b1;
                    w_waddr  = 14'd0;
                    w_x_next = 7'd1;
                    w_y_next = 7'd0;
                    w_next   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    w_write = 1'b1;
                    if (s_sof) begin
                        // restart as a fresh frame; the beat becomes pixel (0,0)
                        w_sof_err = 1'b1;
                        w_waddr   = 14'd0;
                        w_x_next  = 7'd1;
                        w_y_next  = 7'd0;
                    end else begin
                        w_x_next = r_x + 7'd1;
                        if (r_x == X_MAX) begin
                            w_y_next = r_y + 7'd1;
                            if (r_y == Y_MAX) begin
                                w_next = S_HAND;
                            end
                        end
                    end
                end
            end
            S_HAND: begin
                if (busy) begin
                    w_next = S_WAIT;
                end
            end
            default: begin
                if (!busy) begin
                    w_next   = S_IDLE;
                    w_x_next = 7'd0;
                    w_y_next = 7'd0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_x       <= 7'd0;
            r_y       <= 7'd0;
            r_s_ready <= 1'b0;
            r_addr    <= 14'd0;
            r_data    <= 8'd0;
            r_wen     <= 1'b0;
            r_ready   <= 1'b0;
            r_sof_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_x       <= w_x_next;
            r_y       <= w_y_next;
            r_s_ready <= (w_next == S_IDLE) || (w_next == S_LOAD);
            r_wen     <= w_write;
            r_sof_err <= w_sof_err;
            if (w_write) begin
                r_addr <= w_waddr;
                r_data <= s_data;
            end
            // first HAND cycle always raises ready, even if busy is already high
            r_ready   <= (r_state == S_HAND) && (!busy || !r_ready);
        end
    end

`ifdef IMG_LOADER_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= 16'd0;
        end else if (w_write) begin
            r_checksum <= (s_sof ? 16'd0 : r_checksum) + {8'd0, s_data};
        end
    end

    assign checksum = r_checksum;
`endif

    assign s_ready  = r_s_ready;
    assign img_addr = r_addr;
    assign img_data = r_data;
    assign img_wen  = r_wen;
    assign ready    = r_ready;
    assign sof_err  = r_sof_err;

endmodule

// File: tb/tb_img_loader.sv
// Directed self-checking bench for img_loader: frame load, handshake, garbage,
// mid-frame SOF, throttling with reset, and checksum when IMG_LOADER_CHECKSUM_EN is set.
module tb_img_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'd0;
    logic        s_sof = 1'b0;
    logic [13:0] img_addr;
    logic [7:0]  img_data;
    logic        img_wen;
    logic        ready;
    logic        busy = 1'b0;
    logic        sof_err;
`ifdef IMG_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int total = 0;
    int bad = 0;

    logic [7:0] mem [0:16383];
    int wcount = 0;
    int errcount = 0;
    int rises = 0;
    logic ready_q = 1'b0;

    img_loader dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_sof    (s_sof),
        .img_addr (img_addr),
        .img_data (img_data),
        .img_wen  (img_wen),
        .ready    (ready),
        .busy     (busy),
        .sof_err  (sof_err)
`ifdef IMG_LOADER_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    // image memory model and event counters, sampled away from the active edge
    always @(negedge clk) begin
        if (img_wen === 1'b1) begin
            mem[img_addr] <= img_data;
            wcount <= wcount + 1;
        end
        if (sof_err === 1'b1) errcount <= errcount + 1;
        if (ready === 1'b1 && ready_q !== 1'b1) rises <= rises + 1;
        ready_q <= ready;
    end

    function automatic logic [7:0] pix(input int mode, input int x, input int y);
        int s;
        s = x + y;
        return (mode == 1) ? 8'hFF : s[7:0];
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic sof);
        logic acc;
        int   n;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = (s_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL beat_accept_timeout: s_ready=%b required 1", s_ready);
        end
        s_sof = 1'b0;
    endtask

    task automatic send_range(input int mode, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_beat(pix(mode, i % 128, i / 128), (i == 0));
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_timeout: ready=%b required 1", ready);
        end
    endtask

    task automatic finish_hand();
        int n;
        s_valid = 1'b0;
        wait_ready();
        @(posedge clk); #1; busy = 1'b1;
        @(posedge clk); #1; busy = 1'b0;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_timeout: s_ready=%b required 1", s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({s_ready, img_addr, img_data, img_wen, ready, sof_err} !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {s_ready, img_addr, img_data, img_wen, ready, sof_err});
        end
`ifdef IMG_LOADER_CHECKSUM_EN
        total++;
        if (checksum !== 16'd0) begin
            bad++;
            $display("FAIL reset_checksum: got %h required 0000", checksum);
        end
`endif
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL s_ready_before_first_clk: got %b required 0", s_ready);
        end
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL s_ready_after_first_clk: got %b required 1", s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_frame_and_handshake();
        int  base_w, base_r, base_e, hi;
        logic stuck;
        base_w = wcount; base_r = rises; base_e = errcount;
        send_range(0, 0, 16383);
        s_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({img_wen, img_addr, img_data, ready, s_ready} !== {1'b1, 14'h3FFF, 8'hFE, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL last_write: wen=%b addr=%h data=%h ready=%b s_ready=%b required 1 3fff fe 0 0",
                     img_wen, img_addr, img_data, ready, s_ready);
        end
        @(negedge clk);
        total++;
        if (ready !== 1'b1 || img_wen !== 1'b0) begin
            bad++;
            $display("FAIL ready_rise: ready=%b wen=%b required 1 0", ready, img_wen);
        end
        hi = (ready === 1'b1) ? 1 : 0;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            if (ready === 1'b1) hi++;
        end
        @(posedge clk); #1; busy = 1'b1;
        @(negedge clk);
        if (ready === 1'b1) hi++;
        @(negedge clk);
        if (ready === 1'b1) hi++;
        total++;
        if (hi !== 6) begin
            bad++;
            $display("FAIL ready_high_cycles: got %0d required 6", hi);
        end
        stuck = 1'b0;
        repeat (19) begin
            @(negedge clk);
            if (s_ready !== 1'b0 || ready !== 1'b0) stuck = 1'b1;
        end
        @(posedge clk); #1; busy = 1'b0;
        @(negedge clk);
        if (s_ready !== 1'b0) stuck = 1'b1;
        total++;
        if (stuck !== 1'b0) begin
            bad++;
            $display("FAIL s_ready_during_busy: got 1 required 0");
        end
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL s_ready_after_busy: got %b required 1", s_ready);
        end
        @(posedge clk); #1;
        total++;
        if (wcount - base_w !== 16384) begin
            bad++;
            $display("FAIL frame_writes: got %0d required 16384", wcount - base_w);
        end
        total++;
        if (mem[14'h0081] !== 8'd2 || mem[14'h3FFF] !== 8'hFE || mem[643] !== 8'd8) begin
            bad++;
            $display("FAIL frame_contents: m81=%h m3fff=%h m643=%h required 02 fe 08",
                     mem[14'h0081], mem[14'h3FFF], mem[643]);
        end
        total++;
        if (rises - base_r !== 1 || errcount - base_e !== 0) begin
            bad++;
            $display("FAIL ready_rises_once: rises=%0d sof_err=%0d required 1 0",
                     rises - base_r, errcount - base_e);
        end
    endtask

    task automatic test_garbage();
        int base_w;
        base_w = wcount;
        for (int i = 0; i < 10; i++) send_beat(8'h33, 1'b0);
        s_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        total++;
        if (wcount - base_w !== 0) begin
            bad++;
            $display("FAIL garbage_writes: got %0d required 0", wcount - base_w);
        end
        @(posedge clk); #1;
        send_beat(8'h00, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        total++;
        if (img_wen !== 1'b1 || img_addr !== 14'd0) begin
            bad++;
            $display("FAIL garbage_first_write: wen=%b addr=%h required 1 0000", img_wen, img_addr);
        end
        @(posedge clk); #1;
        send_range(0, 1, 16383);
        finish_hand();
        total++;
        if (wcount - base_w !== 16384) begin
            bad++;
            $display("FAIL garbage_frame_writes: got %0d required 16384", wcount - base_w);
        end
    endtask

    task automatic test_mid_sof();
        int base_w, base_e;
        base_w = wcount; base_e = errcount;
        send_range(0, 0, 299);
        send_beat(8'h5A, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({sof_err, img_wen, img_addr, img_data} !== {1'b1, 1'b1, 14'd0, 8'h5A}) begin
            bad++;
            $display("FAIL mid_sof_write: err=%b wen=%b addr=%h data=%h required 1 1 0000 5a",
                     sof_err, img_wen, img_addr, img_data);
        end
        @(negedge clk);
        total++;
        if (sof_err !== 1'b0) begin
            bad++;
            $display("FAIL mid_sof_pulse_width: got %b required 0", sof_err);
        end
        @(posedge clk); #1;
        send_range(0, 1, 16383);
        finish_hand();
        total++;
        if (wcount - base_w !== 16684 || errcount - base_e !== 1) begin
            bad++;
            $display("FAIL mid_sof_counts: writes=%0d errs=%0d required 16684 1",
                     wcount - base_w, errcount - base_e);
        end
        total++;
        if (mem[0] !== 8'h5A || mem[14'h3FFF] !== 8'hFE) begin
            bad++;
            $display("FAIL mid_sof_contents: m0=%h m3fff=%h required 5a fe", mem[0], mem[14'h3FFF]);
        end
    endtask

    task automatic test_throttle_reset();
        int   base_w;
        logic dirty;
        for (int i = 0; i < 5000; i++) begin
            send_beat(8'($urandom_range(0, 255)), (i == 0));
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if ({s_ready, img_addr, img_data, img_wen, ready, sof_err} !== 25'd0) begin
            bad++;
            $display("FAIL async_reset_clear: got %h required 0",
                     {s_ready, img_addr, img_data, img_wen, ready, sof_err});
        end
        dirty = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if ({s_ready, img_addr, img_data, img_wen, ready, sof_err} !== 25'd0) dirty = 1'b1;
        end
        total++;
        if (dirty !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_clear: got 1 required 0");
        end
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
        base_w = wcount;
        for (int i = 0; i < 20; i++) send_beat(8'h11, 1'b0);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (wcount - base_w !== 0) begin
            bad++;
            $display("FAIL writes_before_new_sof: got %0d required 0", wcount - base_w);
        end
        @(posedge clk); #1;
        send_beat(8'h42, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({img_wen, img_addr, img_data} !== {1'b1, 14'd0, 8'h42}) begin
            bad++;
            $display("FAIL new_sof_write: wen=%b addr=%h data=%h required 1 0000 42",
                     img_wen, img_addr, img_data);
        end
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef IMG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        send_range(1, 0, 16383);
        s_valid = 1'b0;
        wait_ready();
        total++;
        if (checksum !== 16'hC000) begin
            bad++;
            $display("FAIL checksum_all_ff: got %h required c000", checksum);
        end
        finish_hand();
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame_and_handshake();
        test_garbage();
        test_mid_sof();
        test_throttle_reset();
`ifdef IMG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
